// File: rtl/mmio_csr_responder.sv
// rtl/mmio_csr_responder.sv - MMIO CSR bank with fixed-latency read responses
// Services host MMIO reads/writes against NUM_CSR 64-bit registers; reg0/reg1 are read-only.
module mmio_csr_responder #(
  parameter int          NUM_CSR    = 16,
  parameter int          RD_LATENCY = 2,
  parameter logic [63:0] AFU_ID     = 64'h0
) (
  input  logic                   Clk_400,
  input  logic                   SoftReset,
  input  logic                   cfg_rdvalid,
  input  logic                   cfg_wrvalid,
  input  logic [27:0]            cfg_hdr,
  input  logic [63:0]            cfg_wrdata,
  input  logic [63:0]            hw_status,
  output logic                   mmio_rdvalid,
  output logic [8:0]             mmio_rdtid,
  output logic [63:0]            mmio_rddata,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     csr_wr_strobe,
  output logic [7:0]             err_cnt
);

  localparam int AW = $clog2(NUM_CSR);

  logic [15:0]   idx;
  logic [1:0]    len;
  logic          poison;
  logic [8:0]    tid;
  logic [AW-1:0] sel;
  logic          in_range;
  logic          acc_ok;
  logic          is_rw;
  logic          wr_ok;
  logic          rd_bad;
  logic          wr_bad;

  assign idx    = cfg_hdr[27:12];
  assign len    = cfg_hdr[11:10];
  assign poison = cfg_hdr[9];
  assign tid    = cfg_hdr[8:0];
  assign sel    = idx[AW:1];

  // One header drives both channels, so legality is decoded once and shared.
  assign in_range = (idx[15:1] < 15'(NUM_CSR));
  assign acc_ok   = in_range && !len[1] && !(len[0] && idx[0]) && !poison;
  assign is_rw    = (sel > AW'(1));
  assign wr_ok    = cfg_wrvalid && acc_ok && is_rw;
  assign rd_bad   = cfg_rdvalid && !acc_ok;
  assign wr_bad   = cfg_wrvalid && !(acc_ok && is_rw);

  logic [63:0] csr_r    [NUM_CSR];
  logic [63:0] csr_view [NUM_CSR];

  always_comb begin
    for (int i = 0; i < NUM_CSR; i++) begin
      csr_view[i] = csr_r[i];
    end
    csr_view[0] = AFU_ID;
    csr_view[1] = hw_status;
    csr_q = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      csr_q[64*i +: 64] = csr_view[i];
    end
  end

  logic [63:0] cur_val;
  logic [63:0] rd_data;
  logic [63:0] wr_val;

  always_comb begin
    cur_val = csr_view[sel];
    rd_data = 64'h0;
    if (acc_ok) begin
      if (len[0]) begin
        rd_data = cur_val;
      end else if (idx[0]) begin
        rd_data = {32'h0, cur_val[63:32]};
      end else begin
        rd_data = {32'h0, cur_val[31:0]};
      end
    end
    if (len[0]) begin
      wr_val = cfg_wrdata;
    end else if (idx[0]) begin
      wr_val = {cfg_wrdata[31:0], cur_val[31:0]};
    end else begin
      wr_val = {cur_val[63:32], cfg_wrdata[31:0]};
    end
  end

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      for (int i = 0; i < NUM_CSR; i++) begin
        csr_r[i] <= 64'h0;
      end
      csr_wr_strobe <= '0;
    end else begin
      for (int i = 2; i < NUM_CSR; i++) begin
        if (wr_ok && (sel == AW'(i))) begin
          csr_r[i] <= wr_val;
        end
      end
      csr_wr_strobe <= wr_ok ? (NUM_CSR'(1) << sel) : '0;
    end
  end

  // Idle stages carry zero tid/data so the output port reads 0 when not valid.
  logic        pv [RD_LATENCY];
  logic [8:0]  pt [RD_LATENCY];
  logic [63:0] pd [RD_LATENCY];

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pt[i] <= 9'h0;
        pd[i] <= 64'h0;
      end
    end else begin
      pv[0] <= cfg_rdvalid;
      pt[0] <= cfg_rdvalid ? tid : 9'h0;
      pd[0] <= cfg_rdvalid ? rd_data : 64'h0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign mmio_rdvalid = pv[RD_LATENCY-1];
  assign mmio_rdtid   = pt[RD_LATENCY-1];
  assign mmio_rddata  = pd[RD_LATENCY-1];

  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign err_inc = {1'b0, rd_bad} + {1'b0, wr_bad};
  assign err_sum = {1'b0, err_cnt} + {7'h0, err_inc};

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      err_cnt <= 8'h0;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_csr_responder.sv
// tb/tb_mmio_csr_responder.sv - directed self-checking bench for mmio_csr_responder
module tb_mmio_csr_responder;

  localparam int          NUM_CSR = 16;
  localparam logic [63:0] AFU_ID  = 64'hDEADBEEF_CAFEF00D;

  logic                  Clk_400 = 1'b0;
  logic                  SoftReset;
  logic                  cfg_rdvalid;
  logic                  cfg_wrvalid;
  logic [27:0]           cfg_hdr;
  logic [63:0]           cfg_wrdata;
  logic [63:0]           hw_status;
  logic                  mmio_rdvalid;
  logic [8:0]            mmio_rdtid;
  logic [63:0]           mmio_rddata;
  logic [NUM_CSR*64-1:0] csr_q;
  logic [NUM_CSR-1:0]    csr_wr_strobe;
  logic [7:0]            err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 Clk_400 = ~Clk_400;

  mmio_csr_responder #(
    .NUM_CSR(NUM_CSR), .RD_LATENCY(2), .AFU_ID(AFU_ID)
  ) dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset),
    .cfg_rdvalid(cfg_rdvalid), .cfg_wrvalid(cfg_wrvalid),
    .cfg_hdr(cfg_hdr), .cfg_wrdata(cfg_wrdata), .hw_status(hw_status),
    .mmio_rdvalid(mmio_rdvalid), .mmio_rdtid(mmio_rdtid), .mmio_rddata(mmio_rddata),
    .csr_q(csr_q), .csr_wr_strobe(csr_wr_strobe), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] hdr(input logic [15:0] idx, input logic [1:0] len,
                                      input logic poison, input logic [8:0] tid);
    return {idx, len, poison, tid};
  endfunction

  function automatic logic [63:0] reg_q(input int i);
    return csr_q[64*i +: 64];
  endfunction

  // Request in the cycle after negedge N0; response sampled at N2.
  task automatic rd(input string tag, input logic [15:0] idx, input logic [1:0] len,
                    input logic [8:0] tid, input logic [63:0] exp);
    @(negedge Clk_400);
    cfg_rdvalid = 1'b1;
    cfg_hdr     = hdr(idx, len, 1'b0, tid);
    @(negedge Clk_400);
    cfg_rdvalid = 1'b0;
    cfg_hdr     = '0;
    check({tag, "_early"}, 64'(mmio_rdvalid), 64'd0);
    @(negedge Clk_400);
    check({tag, "_valid"}, 64'(mmio_rdvalid), 64'd1);
    check({tag, "_tid"}, 64'(mmio_rdtid), 64'(tid));
    check({tag, "_data"}, mmio_rddata, exp);
    @(negedge Clk_400);
    check({tag, "_idle"}, {55'h0, mmio_rdvalid, mmio_rdtid}, 64'd0);
  endtask

  task automatic wr(input logic [15:0] idx, input logic [1:0] len, input logic poison,
                    input logic [63:0] data);
    @(negedge Clk_400);
    cfg_wrvalid = 1'b1;
    cfg_hdr     = hdr(idx, len, poison, 9'h0);
    cfg_wrdata  = data;
    @(negedge Clk_400);
    cfg_wrvalid = 1'b0;
    cfg_hdr     = '0;
    cfg_wrdata  = '0;
  endtask

  initial begin
    logic seen;
    SoftReset   = 1'b1;
    cfg_rdvalid = 1'b0;
    cfg_wrvalid = 1'b0;
    cfg_hdr     = '0;
    cfg_wrdata  = '0;
    hw_status   = 64'h0123_4567_89AB_CDEF;
    repeat (3) @(negedge Clk_400);
    SoftReset = 1'b0;
    check("rst_rdvalid", 64'(mmio_rdvalid), 64'd0);
    check("rst_rdtid", 64'(mmio_rdtid), 64'd0);
    check("rst_rddata", mmio_rddata, 64'd0);
    check("rst_strobe", 64'(csr_wr_strobe), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_reg2", reg_q(2), 64'd0);

    rd("rd_afu_id", 16'd0, 2'd1, 9'h1A5, AFU_ID);
    check("err_after_id", 64'(err_cnt), 64'd0);

    wr(16'd4, 2'd1, 1'b0, 64'h1122334455667788);
    check("wr64_strobe", 64'(csr_wr_strobe), 64'h4);
    check("wr64_reg2", reg_q(2), 64'h1122334455667788);
    wr(16'd5, 2'd0, 1'b0, 64'hFFFF0000_AAAA5555);
    check("wr32_strobe", 64'(csr_wr_strobe), 64'h4);
    check("wr32_reg2", reg_q(2), 64'hAAAA5555_55667788);
    @(negedge Clk_400);
    check("strobe_clear", 64'(csr_wr_strobe), 64'd0);
    rd("rd32_hi", 16'd5, 2'd0, 9'h011, 64'h00000000_AAAA5555);
    rd("rd32_lo", 16'd4, 2'd0, 9'h012, 64'h00000000_55667788);
    rd("rd_status", 16'd2, 2'd1, 9'h013, 64'h0123_4567_89AB_CDEF);
    rd("rd_status_hi", 16'd3, 2'd0, 9'h014, 64'h00000000_01234567);

    // Same-cycle read and write of reg3, then a follow-up read.
    @(negedge Clk_400);
    cfg_rdvalid = 1'b1;
    cfg_wrvalid = 1'b1;
    cfg_hdr     = hdr(16'd6, 2'd1, 1'b0, 9'h003);
    cfg_wrdata  = 64'hFF;
    @(negedge Clk_400);
    cfg_wrvalid = 1'b0;
    cfg_hdr     = hdr(16'd6, 2'd1, 1'b0, 9'h004);
    check("rw_strobe", 64'(csr_wr_strobe), 64'h8);
    @(negedge Clk_400);
    cfg_rdvalid = 1'b0;
    cfg_hdr     = '0;
    check("rw_old_valid", 64'(mmio_rdvalid), 64'd1);
    check("rw_old_tid", 64'(mmio_rdtid), 64'h3);
    check("rw_old_data", mmio_rddata, 64'h0);
    @(negedge Clk_400);
    check("rw_new_tid", 64'(mmio_rdtid), 64'h4);
    check("rw_new_data", mmio_rddata, 64'hFF);
    @(negedge Clk_400);

    // Back-to-back reads: sample first, then drive, each negedge.
    for (int k = 0; k <= 10; k++) begin
      @(negedge Clk_400);
      if (k >= 2 && k < 10) begin
        check($sformatf("b2b_valid%0d", k - 2), 64'(mmio_rdvalid), 64'd1);
        check($sformatf("b2b_tid%0d", k - 2), 64'(mmio_rdtid), 64'(k - 2));
        check($sformatf("b2b_data%0d", k - 2), mmio_rddata, AFU_ID);
      end else if (k == 10) begin
        check("b2b_done", 64'(mmio_rdvalid), 64'd0);
      end
      cfg_rdvalid = (k < 8);
      cfg_hdr     = (k < 8) ? hdr(16'd0, 2'd1, 1'b0, 9'(k)) : '0;
    end

    rd("rd_misalign", 16'd3, 2'd1, 9'h0A1, 64'h0);
    check("err_misalign", 64'(err_cnt), 64'd1);
    wr(16'd0, 2'd1, 1'b0, 64'h1234);
    check("wr_ro_strobe", 64'(csr_wr_strobe), 64'd0);
    check("wr_ro_reg0", reg_q(0), AFU_ID);
    check("err_wr_ro", 64'(err_cnt), 64'd2);
    rd("rd_oor", 16'(2 * NUM_CSR), 2'd1, 9'h0A2, 64'h0);
    check("err_oor", 64'(err_cnt), 64'd3);

    @(negedge Clk_400);
    cfg_rdvalid = 1'b1;
    cfg_wrvalid = 1'b1;
    cfg_hdr     = hdr(16'(2 * NUM_CSR), 2'd1, 1'b0, 9'h0A3);
    @(negedge Clk_400);
    cfg_rdvalid = 1'b0;
    cfg_wrvalid = 1'b0;
    cfg_hdr     = '0;
    check("err_double", 64'(err_cnt), 64'd5);
    repeat (2) @(negedge Clk_400);
    rd("rd_len2", 16'd4, 2'd2, 9'h0A4, 64'h0);
    check("err_len2", 64'(err_cnt), 64'd6);

    for (int i = 0; i < 300; i++) begin
      wr(16'd4, 2'd1, 1'b1, 64'hFFFF);
    end
    check("err_sat", 64'(err_cnt), 64'hFF);
    check("poison_reg2", reg_q(2), 64'hAAAA5555_55667788);

    // Reset one cycle after a read request: that read must vanish.
    @(negedge Clk_400);
    cfg_rdvalid = 1'b1;
    cfg_hdr     = hdr(16'd4, 2'd1, 1'b0, 9'h055);
    @(negedge Clk_400);
    cfg_rdvalid = 1'b0;
    cfg_hdr     = '0;
    SoftReset   = 1'b1;
    seen        = mmio_rdvalid;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk_400);
      if (i == 1) SoftReset = 1'b0;
      seen = seen | mmio_rdvalid;
    end
    check("rst_mid_norsp", 64'(seen), 64'd0);
    check("rst_mid_reg2", reg_q(2), 64'd0);
    check("rst_mid_reg3", reg_q(3), 64'd0);
    check("rst_mid_err", 64'(err_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_csr_responder.md
Name: mmio_csr_responder

Overview:
- AFU-side responder for host-initiated CCI-P MMIO traffic. It services the MMIO read and write requests the emulator issues.
- Owns a bank of NUM_CSR 64-bit registers and returns one read response per read request, at fixed latency, with the request TID echoed.
- Sits between the emulator's config channel and user AFU logic. Exposes register contents and write strobes to the AFU.

Parameters:
- NUM_CSR, 16, number of 64-bit registers; minimum 4; power of two.
- RD_LATENCY, 2, cycles from read-request acceptance to response; minimum 1.
- AFU_ID, 64'h0, constant returned by register 0.

Ports:
- Clk_400  in  1  sole clock.
- SoftReset  in  1  reset.
- cfg_rdvalid  in  1  MMIO read request valid.
- cfg_wrvalid  in  1  MMIO write request valid.
- cfg_hdr  in  28  CfgHdr_t {index[15:0], len[1:0], poison, tid[8:0]}.
- cfg_wrdata  in  64  write data; a 32-bit write uses [31:0].
- hw_status  in  64  AFU status word, read-only through register 1.
- mmio_rdvalid  out  1  read response valid.
- mmio_rdtid  out  9  echoed TID.
- mmio_rddata  out  64  read data.
- csr_q  out  NUM_CSR*64  register contents; register i occupies bits [64i+63:64i].
- csr_wr_strobe  out  NUM_CSR  one-cycle pulse when register i is written.
- err_cnt  out  8  saturating count of illegal requests.

Interface reset and clocking (already decided): one clock, Clk_400; SoftReset is synchronous and active-high.

Behaviour:
- Reset values: all RW registers 0; read pipeline valid bits 0; mmio_rdvalid=0, mmio_rdtid=0, mmio_rddata=0, csr_wr_strobe=0, err_cnt=0.
- Reset asserted mid-operation discards in-flight reads; no response is ever issued for them.
- Addressing:
  - index is a 4-byte (DWORD) index.
  - len=0 is a 32-bit access; len=1 is a 64-bit access; len=2 or 3 is illegal.
  - Register select reg = index[15:1]; in range when reg < NUM_CSR.
  - 64-bit accesses require index[0]=0, otherwise illegal.
  - For 32-bit accesses, index[0] selects the lower (0) or upper (1) half.
- Register map:
  - reg0: read-only, returns AFU_ID.
  - reg1: read-only, returns hw_status sampled in the request cycle.
  - reg2..NUM_CSR-1: read/write.
- Writes (cfg_wrvalid at cycle T):
  - A legal write to an RW register updates csr_q at T+1 and pulses csr_wr_strobe[reg] during T+1.
  - A 32-bit write modifies only the addressed half.
  - Dropped writes: writes to RO registers, out-of-range index, illegal len, misalignment, or poison=1. Each dropped write increments err_cnt.
- Reads (cfg_rdvalid at cycle T):
  - Data is sampled at T (read-before-write).
  - The response appears at T+RD_LATENCY: mmio_rdvalid=1 for exactly one cycle, mmio_rdtid = request tid.
  - 32-bit read: the addressed dword is placed in [31:0]; [63:32]=0.
  - Illegal read (out-of-range, illegal len, misaligned, poison): still responds, with data 64'h0, and increments err_cnt.
  - When mmio_rdvalid=0, mmio_rdtid and mmio_rddata hold 0.
- Pipeline:
  - Shift register of {valid, tid, data}, RD_LATENCY deep. Accepts one read every cycle with no backpressure.
  - Back-to-back reads produce back-to-back responses, in order.
- Simultaneous cfg_rdvalid and cfg_wrvalid in the same cycle: both are serviced. The read returns the pre-write value.
- A single cycle with two illegal events (illegal read + illegal write) adds 2 to err_cnt.
- err_cnt saturates at 8'hFF and never wraps.
- No state machine beyond the pipeline. The block is fully pipelined at one request per channel per cycle.

Test Plan:
- Reset, then 64-bit read of index 0 tid=9'h1A5 with AFU_ID=64'hDEADBEEF_CAFEF00D -> at T+2, mmio_rdvalid=1, mmio_rdtid=9'h1A5, mmio_rddata=64'hDEADBEEF_CAFEF00D; err_cnt=0.
- 64-bit write of 64'h1122334455667788 to index 4 (reg2), then 32-bit write of 32'hAAAA5555 to index 5 -> csr_wr_strobe[2] pulses twice; csr_q reg2 = 64'hAAAA5555_55667788. A 32-bit read of index 5 returns 64'h00000000_AAAA5555.
- Same-cycle read and 64-bit write of 64'hFF to reg3 (reg3 was 0) -> read response data=0. A read in the next cycle returns 64'hFF.
- Eight back-to-back reads with tids 0..7 -> eight consecutive response cycles with tids 0..7 in order, each at its request cycle +2.
- Illegal cases:
  - 64-bit read at index 3 (misaligned) -> response data 0, err_cnt=1.
  - Write to reg0 -> reg0 unchanged, err_cnt=2.
  - Read at index 2*NUM_CSR (out of range) -> data 0, err_cnt=3.
  - 300 poisoned writes -> err_cnt=8'hFF.
- SoftReset asserted one cycle after a read request -> no mmio_rdvalid ever issued for that read; all RW registers 0, err_cnt=0.
